data_mem_responder: RTL

//   Multi-cycle data-memory responder: the memory-side end of the MEM-stage load/store interface.

---
 rtl/data_mem_responder.sv | 87 ++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle word memory answering one MEM-stage load/store at a time
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd_en,
  input  logic        req_wr_en,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rsp_rdata,
  output logic        rsp_ready,
  output logic        busy,
  output logic        addr_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          illegal, commit;
  assign off       = addr_q - 32'(BASE_ADDR);
  assign idx       = off[AW+1:2];
  assign illegal   = (rd_q & wr_q) | (addr_q < 32'(BASE_ADDR)) | ((off >> 2) >= 32'(DEPTH)) | (addr_q[1:0] != 2'b00);
  assign commit    = (state_q == WAIT) && (cnt_q == '0);
  assign rsp_ready = state_q == DONE;
  assign busy      = state_q == WAIT;
  assign addr_err  = rsp_ready & illegal;
  assign rsp_rdata = rdata_q;
  // next state: latch the request in IDLE, count down in WAIT, load read data on the edge into DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == IDLE) begin
      if (req_rd_en | req_wr_en) begin
        rd_d    = req_rd_en;
        wr_d    = req_wr_en;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        cnt_d   = CW'(WAIT_CYCLES - 1);
        state_d = WAIT;
      end
    end else if (state_q == WAIT) begin
      cnt_d   = commit ? cnt_q : cnt_q - 1'b1;
      state_d = commit ? DONE : WAIT;
      rdata_d = (commit && rd_q) ? (illegal ? 32'h0 : mem[idx]) : rdata_q;
    end else begin
      state_d = IDLE;
    end
  end
  // state and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // array write commits on the edge into DONE; a reset in WAIT discards it
  always_ff @(posedge clk) begin
    if (!rst && commit && wr_q && !illegal) mem[idx] <= wdata_q;
  end
endmodule
